// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage controller.
// Owns the PC, requests instructions from a variable-latency memory, and
// drives the producer side of the IF/ID pipeline register.
// Holds a fetched word while decode stalls.
// Injects a NOP bubble on a taken-branch redirect.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   stall                IF/ID must not be written this cycle
//   branch_taken/target  redirect request and its PC
//   imem_req/addr        memory request, address = PC
//   imem_ready/rdata     memory response for the address of the same cycle
//   PR0_PC_plus1         PC+1 of the presented instruction (target on redirect)
//   PR0_instruction      instruction presented to IF/ID (0 = NOP bubble)
//   if_id_write_en       IF/ID write enable
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module if_fetch_unit #(
  parameter int ADDR_W  = `ADDRESS_LEN,
  parameter int INSTR_W = `INSTRUCTION_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PR0_PC_plus1,
  output logic [INSTR_W-1:0] PR0_instruction,
  output logic               if_id_write_en
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt, pc_inc;
  logic [INSTR_W-1:0] hold_instr, hold_nxt;

  // Wraps modulo 2^ADDR_W.
  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    hold_nxt        = hold_instr;
    imem_req        = (state == S_REQ);
    imem_addr       = pc;
    PR0_PC_plus1    = pc_inc;
    PR0_instruction = hold_instr;
    if_id_write_en  = 1'b0;

    if (branch_taken) begin
      // Redirect beats stall, held word and any same-cycle memory data.
      if_id_write_en  = 1'b1;
      PR0_instruction = '0;
      PR0_PC_plus1    = branch_target;
      pc_nxt          = branch_target;
      state_nxt       = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          PR0_instruction = imem_rdata;
          if (imem_ready && !stall) begin
            if_id_write_en = 1'b1;
            pc_nxt         = pc_inc;
          end else if (imem_ready) begin
            // Capture the word now; the memory need not hold it for us.
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_id_write_en = 1'b1;
            pc_nxt         = pc_inc;
            state_nxt      = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end

    // While reset is held, state sits at S_REQ/pc=0 and the stage simply
    // reflects whatever the memory returns for address 0.
    if (rst) begin
      imem_req        = 1'b1;
      imem_addr       = pc;
      PR0_PC_plus1    = pc_inc;
      PR0_instruction = imem_rdata;
      if_id_write_en  = imem_ready;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, branch_taken, imem_ready;
  logic [AW-1:0] branch_target;
  logic [IW-1:0] imem_rdata;
  logic          imem_req, if_id_write_en;
  logic [AW-1:0] imem_addr, PR0_PC_plus1;
  logic [IW-1:0] PR0_instruction;

  if_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PR0_PC_plus1(PR0_PC_plus1), .PR0_instruction(PR0_instruction),
    .if_id_write_en(if_id_write_en));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc1;
    logic [IW-1:0] ins;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every IF/ID write outside reset must match the next queued entry.
  always @(negedge clk) begin
    if (!done && rst === 1'b0 && if_id_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'h0, PR0_PC_plus1}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_pc_plus1", {24'h0, PR0_PC_plus1}, {24'h0, e.pc1});
        chk("wr_instr", {16'h0, PR0_instruction}, {16'h0, e.ins});
      end
    end
  end

  // One cycle of stimulus: drive inputs, optionally queue the expected
  // write, check request/address at mid-cycle, advance to after next edge.
  task automatic step(input logic st, input logic br, input logic [AW-1:0] tgt,
                      input logic rdy, input logic [IW-1:0] rd,
                      input logic e_req, input logic [AW-1:0] e_addr,
                      input logic push, input logic [AW-1:0] e_pc1,
                      input logic [IW-1:0] e_ins);
    wr_t w;
    stall = st; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_rdata = rd;
    if (push) begin
      w.pc1 = e_pc1; w.ins = e_ins;
      exp_q.push_back(w);
    end
    @(negedge clk);
    chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) chk("imem_addr", {24'h0, imem_addr}, {24'h0, e_addr});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b1; imem_rdata = 16'h0010;
    #12;
    // Outputs while in reset.
    chk("rst_req", {31'h0, imem_req}, 32'h1);
    chk("rst_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_pc1", {24'h0, PR0_PC_plus1}, 32'h1);
    chk("rst_wen", {31'h0, if_id_write_en}, 32'h1);
    imem_ready = 1'b0; #1;
    chk("rst_wen_nr", {31'h0, if_id_write_en}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait stream: rdata = 0x10+addr.
    for (int a = 0; a < 5; a++)
      step(0, 0, 0, 1, 16'(16'h10 + a), 1, 8'(a), 1, 8'(a + 1), 16'(16'h10 + a));
    // Three wait states at pc=5.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 16'hDEAD, 1, 8'h05, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0015, 1, 8'h05, 1, 8'h06, 16'h0015);
    step(0, 0, 0, 1, 16'h0016, 1, 8'h06, 1, 8'h07, 16'h0016);
    // Stall with hold at pc=7.
    step(1, 0, 0, 1, 16'h00AB, 1, 8'h07, 0, 0, 0);
    step(1, 0, 0, 1, 16'h00FF, 0, 0, 0, 0, 0);
    chk("hold_instr_out", {16'h0, PR0_instruction}, 32'h00AB);
    step(1, 0, 0, 1, 16'h00FF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h00FF, 0, 0, 1, 8'h08, 16'h00AB);
    // Next request at 8; stall again into S_HOLD.
    step(1, 0, 0, 1, 16'h0018, 1, 8'h08, 0, 0, 0);
    // Redirect from S_HOLD with stall high.
    step(1, 1, 8'h40, 1, 16'h00EE, 0, 0, 1, 8'h40, 16'h0000);
    step(0, 0, 0, 1, 16'h0050, 1, 8'h40, 1, 8'h41, 16'h0050);
    // Wrap: redirect to all-ones, accept it, next address 0.
    step(0, 1, 8'hFF, 1, 16'h0051, 1, 8'h41, 1, 8'hFF, 16'h0000);
    step(0, 0, 0, 1, 16'h0077, 1, 8'hFF, 1, 8'h00, 16'h0077);
    step(0, 0, 0, 0, 16'h0000, 1, 8'h00, 0, 0, 0);
    // Back-to-back redirects, last target wins.
    step(0, 1, 8'h20, 0, 16'h0000, 1, 8'h00, 1, 8'h20, 16'h0000);
    step(1, 1, 8'h30, 0, 16'h0000, 1, 8'h20, 1, 8'h30, 16'h0000);
    // Enter S_HOLD at 0x30, then reset asynchronously mid-cycle.
    step(1, 0, 0, 1, 16'h0099, 1, 8'h30, 0, 0, 0);
    imem_ready = 1'b0; stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h1);
    chk("arst_addr", {24'h0, imem_addr}, 32'h0);
    chk("arst_pc1", {24'h0, PR0_PC_plus1}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    // Held word gone: back in S_REQ fetching address 0.
    step(0, 0, 0, 1, 16'h0010, 1, 8'h00, 1, 8'h01, 16'h0010);
    step(0, 0, 0, 0, 16'h0000, 1, 8'h01, 0, 0, 0);

    done = 1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage controller. It drives the producer side of the IF/ID pipeline register: `PR0_PC_plus1`, `PR0_instruction` and the register's `write_en`. It owns the program counter and issues requests to a variable-latency instruction memory. It holds a fetched instruction while the decode side stalls, and injects a NOP bubble on a taken-branch redirect.

## Interface
- `ADDR_W`, default `` `ADDRESS_LEN ``: PC / instruction-address width.
- `INSTR_W`, default `` `INSTRUCTION_LEN ``: instruction width; the all-zero word is the NOP.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: the IF/ID register must not be written this cycle (hazard unit).
- `branch_taken` in 1: redirect request from a later stage.
- `branch_target` in ADDR_W: redirect PC, valid when `branch_taken`=1.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out ADDR_W: request address, equal to the PC.
- `imem_ready` in 1: `imem_rdata` is valid for the `imem_addr` of the same cycle.
- `imem_rdata` in INSTR_W: fetched instruction.
- `PR0_PC_plus1` out ADDR_W: PC+1 of the instruction presented.
- `PR0_instruction` out INSTR_W: instruction presented to IF/ID.
- `if_id_write_en` out 1: drives IF/ID `write_en`.

## Operation
- State: `pc` (ADDR_W), `hold_instr` (INSTR_W), FSM {S_REQ, S_HOLD}.
- S_REQ
  - `imem_req`=1, `imem_addr`=`pc`.
  - `PR0_instruction`=`imem_rdata`, `PR0_PC_plus1`=`pc`+1.
  - `imem_ready` & !`stall`: `if_id_write_en`=1; `pc`<=`pc`+1; stay in S_REQ.
  - `imem_ready` & `stall`: `if_id_write_en`=0; `hold_instr`<=`imem_rdata`; go to S_HOLD; `pc` unchanged.
  - !`imem_ready`: `if_id_write_en`=0; stay in S_REQ.
- S_HOLD
  - `imem_req`=0.
  - `PR0_instruction`=`hold_instr`, `PR0_PC_plus1`=`pc`+1.
  - !`stall`: `if_id_write_en`=1; `pc`<=`pc`+1; go to S_REQ.
  - `stall`: `if_id_write_en`=0; stay in S_HOLD.
- Redirect: `branch_taken`=1 has priority over everything, in either state.
  - `if_id_write_en`=1, `PR0_instruction`=0 (bubble), `PR0_PC_plus1`=`branch_target`.
  - `pc`<=`branch_target`; go to S_REQ.
  - The held instruction, any same-cycle `imem_rdata`, and `stall` are ignored. The bubble is written even when `stall`=1.
- `imem_addr` may change on any cycle, including with a request pending and no ready. The memory is not required to complete abandoned requests.
- Arithmetic: `pc`+1 wraps modulo 2^ADDR_W; all-ones+1 = 0.
- `imem_rdata` is a don't-care when `imem_ready`=0.

## Timing
- Reset values: `pc`=0, FSM=S_REQ, `hold_instr`=0.
- Outputs during reset: `imem_req`=1, `imem_addr`=0, `PR0_PC_plus1`=1, `if_id_write_en`=`imem_ready`.
- Reset mid-operation discards any held instruction; state returns to the reset values at once, asynchronously.
- All outputs are combinational from state and inputs; there is no extra register stage.
- Latency: an instruction is written into IF/ID at the same edge where `imem_ready`=1 and `stall`=0.
- Throughput: one instruction per cycle with a zero-wait memory.
- Stall release from S_HOLD:
  - Held instruction written at the first edge with `stall`=0.
  - Next memory request issued in the following cycle.
  - Cost: one-cycle gap.
- Redirect:
  - Bubble written at the `branch_taken` edge.
  - Target fetch requested in the next cycle.
  - Target instruction enters IF/ID no earlier than one cycle after the bubble.
- Back-to-back `branch_taken` cycles: each cycle writes a bubble; the last target wins.

## Test plan
- Zero-wait stream:
  - Stimulus: reset, `imem_ready`=1, rdata = 0x10+addr, no stall.
  - Response: write_en=1 every cycle; PR0 pairs (1,0x10), (2,0x11), (3,0x12).
- Wait states:
  - Stimulus: `imem_ready` low for 3 cycles at `pc`=5.
  - Response: write_en=0 for 3 cycles; `imem_addr` held at 5; then write_en=1 with PC_plus1=6.
- Stall with hold:
  - Stimulus: ready & stall at `pc`=7, rdata=0xAB; stall held 2 more cycles, rdata changed to 0xFF.
  - Response: S_HOLD; `imem_req`=0; on release write_en=1, instruction=0xAB, PC_plus1=8; next cycle `imem_addr`=8.
- Redirect priority:
  - Stimulus: in S_HOLD with stall=1, `branch_taken`=1, target=0x40.
  - Response: write_en=1, instruction=0, PC_plus1=0x40; next cycle `imem_addr`=0x40, state S_REQ.
- Wrap and reset:
  - Stimulus: `pc`=all-ones accepted.
  - Response: next `imem_addr`=0.
  - Stimulus: assert `rst` asynchronously in S_HOLD.
  - Response: immediately `imem_addr`=0, `imem_req`=1, held word discarded.
